// File: rtl/snn_pkg.sv
// snn_pkg: shared defaults, potential type, FSM states and saturating add for the LIF array (sat_add used under LIF_SATURATE_EN)
package snn_pkg;
  localparam int DEFAULT_WIDTH = 32;
  typedef logic signed [DEFAULT_WIDTH-1:0] potential_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    logic signed [63:0] s, hi, lo;
    s = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return s > hi ? hi : (s < lo ? lo : s);
  endfunction
endpackage

// File: rtl/lif_neuron_array_if.sv
// lif_neuron_array_if: weight events in, spike IDs out and step control between decoder, LIF array and packetiser
interface lif_neuron_array_if import snn_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NUM_NEURONS = 4,
  parameter int ID_W = $clog2(NUM_NEURONS)
);
  logic [WIDTH-1:0] v_threshold, v_reset, in_weight;
  logic [ID_W-1:0] in_id, spike_id;
  logic in_valid, in_ready, step_end, spike_valid, spike_ready, step_done, step_overrun;
  modport master(
    output v_threshold, v_reset, in_valid, in_id, in_weight, step_end, spike_ready,
    input in_ready, spike_valid, spike_id, step_done, step_overrun
  );
  modport slave(
    input v_threshold, v_reset, in_valid, in_id, in_weight, step_end, spike_ready,
    output in_ready, spike_valid, spike_id, step_done, step_overrun
  );
endinterface

// File: rtl/lif_neuron_update.sv
// lif_neuron_update: combinational accumulate, threshold test and reset/leak for one neuron (LIF_SATURATE_EN clamps accumulation)
module lif_neuron_update import snn_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DECAY_SHIFT = 3
) (
  input  logic signed [WIDTH-1:0] i_p,
  input  logic signed [WIDTH-1:0] i_weight,
  input  logic signed [WIDTH-1:0] i_threshold,
  input  logic signed [WIDTH-1:0] i_reset,
  input  logic                    i_mode,
  output logic signed [WIDTH-1:0] o_acc,
  output logic                    o_spike,
  output logic signed [WIDTH-1:0] o_post
);
`ifdef LIF_SATURATE_EN
  assign o_acc = WIDTH'(sat_add(64'(i_p), 64'(i_weight), WIDTH));
`else
  assign o_acc = i_p + i_weight;
`endif
  assign o_spike = i_mode && i_p >= i_threshold;
  assign o_post = o_spike ? i_reset : i_p - (i_p >>> DECAY_SHIFT);
endmodule

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: time-multiplexed LIF neurons, handshaked event accumulation and back-pressured spike sweep (LIF_SATURATE_EN: saturating accumulation)
module lif_neuron_array import snn_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NUM_NEURONS = 4,
  parameter int DECAY_SHIFT = 3,
  parameter int ID_W = $clog2(NUM_NEURONS)
) (
  input logic clk,
  input logic rst,
  lif_neuron_array_if.slave io_bus
);
  state_t r_state;
  logic [ID_W-1:0] r_idx;
  logic signed [WIDTH-1:0] r_p [NUM_NEURONS];
  logic r_overrun;
  logic [ID_W-1:0] w_sel;
  logic signed [WIDTH-1:0] w_acc, w_post;
  logic w_sweep, w_spike, w_accept, w_advance, w_last;
  assign w_sweep = r_state == SWEEP;
  assign w_sel = w_sweep ? r_idx : io_bus.in_id;
  // out-of-range ids are still handshaked, just never written
  assign w_accept = r_state == IDLE && io_bus.in_valid && 32'(io_bus.in_id) < NUM_NEURONS;
  assign w_advance = w_sweep && (!w_spike || io_bus.spike_ready);
  assign w_last = r_idx == ID_W'(NUM_NEURONS - 1);
  lif_neuron_update #(.WIDTH(WIDTH), .DECAY_SHIFT(DECAY_SHIFT)) u_update (
    .i_p(r_p[w_sel]),
    .i_weight(signed'(io_bus.in_weight)),
    .i_threshold(signed'(io_bus.v_threshold)),
    .i_reset(signed'(io_bus.v_reset)),
    .i_mode(w_sweep),
    .o_acc(w_acc),
    .o_spike(w_spike),
    .o_post(w_post)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_overrun <= 1'b0;
      for (int k = 0; k < NUM_NEURONS; k++) r_p[k] <= '0;
    end else begin
      r_overrun <= io_bus.step_end && r_state != IDLE;
      if (w_accept) r_p[w_sel] <= w_acc;
      if (w_advance) begin
        r_p[w_sel] <= w_post;
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      case (r_state)
        IDLE:    if (io_bus.step_end) r_state <= SWEEP;
        SWEEP:   if (w_advance && w_last) r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign io_bus.in_ready = r_state == IDLE;
  assign io_bus.spike_valid = w_spike;
  assign io_bus.spike_id = r_idx;
  assign io_bus.step_done = r_state == DONE;
  assign io_bus.step_overrun = r_overrun;
endmodule
